// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared state encoding and constants for the fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_out_buf
// Purpose  : Single-entry instruction/PC holding buffer with load, clear and valid.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_out_buf
    import fetch_pkg::*;
#(
    parameter int WORD    = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [WORD-1:0]    load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [WORD-1:0]    pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [WORD-1:0]    r_pc;

    // Load wins over clear; contents stay put while neither is asserted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_instr <= load_instr;
            r_pc    <= load_pc;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign instr = r_instr;
    assign pc    = r_pc;

endmodule : fetch_out_buf
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Owns the fetch PC, issues imem reads and buffers results for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              WORD     = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WORD-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [WORD-1:0]    if_pc,
    input  logic               br_taken,
    input  logic [WORD-1:0]    br_target
);

    fetch_state_t    r_state;
    logic [WORD-1:0] r_pc;
    logic [WORD-1:0] r_pend_pc;
    logic            r_live;

    logic [WORD-1:0] w_target;
    logic [WORD-1:0] w_pc_next;
    logic            w_load;
    logic            w_clear;

    assign w_target  = br_target & ~(WORD'(INSTR_BYTES - 1));
    assign w_pc_next = r_pc + WORD'(INSTR_BYTES);

    // r_live masks the request for the first cycle out of reset so outputs stay quiet in reset.
    assign w_load  = r_live && (r_state == S_ISSUE) && imem_ack && !br_taken;
    assign w_clear = (r_state == S_HOLD) && (br_taken || if_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_ISSUE;
            r_pc      <= RESET_PC;
            r_pend_pc <= RESET_PC;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_ISSUE: begin
                    if (r_live) begin
                        if (br_taken) begin
                            if (imem_ack) begin
                                r_pc <= w_target;
                            end else begin
                                r_pend_pc <= w_target;
                                r_state   <= S_DRAIN;
                            end
                        end else if (imem_ack) begin
                            r_pc    <= w_pc_next;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (br_taken) begin
                        r_pc    <= w_target;
                        r_state <= S_ISSUE;
                    end else if (if_ready) begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    // A redirect coinciding with the draining ack is the newest target.
                    if (imem_ack) begin
                        r_pc    <= br_taken ? w_target : r_pend_pc;
                        r_state <= S_ISSUE;
                    end else if (br_taken) begin
                        r_pend_pc <= w_target;
                    end
                end
                default: r_state <= S_ISSUE;
            endcase
        end
    end

    assign imem_req  = r_live && (r_state != S_HOLD);
    assign imem_addr = r_live ? r_pc : '0;

    fetch_out_buf #(
        .WORD    (WORD),
        .INSTR_W (INSTR_W)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .clear      (w_clear),
        .load_instr (imem_rdata),
        .load_pc    (r_pc),
        .valid      (if_valid),
        .instr      (if_instr),
        .pc         (if_pc)
    );

endmodule : fetch_sequencer
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Directed and randomized scoreboard bench for fetch_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        br_taken;
    logic [63:0] br_target;

    int checks = 0;
    int errors = 0;
    bit sb_en  = 0;

    logic [63:0] addr_q[$];
    logic [95:0] deliv_q[$];

    // Reference model: one outstanding read or one buffered instruction at a time.
    logic [63:0] m_pc;
    logic [63:0] m_pend;
    logic [63:0] m_buf_pc;
    logic [31:0] m_buf_instr;
    bit          m_full;
    bit          m_stale;

    fetch_sequencer #(
        .WORD     (64),
        .INSTR_W  (32),
        .RESET_PC (64'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation whenever the DUT completes a read or hands over an instruction.
    always @(negedge clk) begin
        logic [63:0] e_addr;
        logic [95:0] e_del;
        if (sb_en) begin
            if (imem_ack) begin
                if (addr_q.size() == 0) begin
                    chk("fetch_unexpected", imem_addr, 64'hX);
                end else begin
                    e_addr = addr_q.pop_front();
                    chk("fetch_req", {63'd0, imem_req}, 64'd1);
                    chk("fetch_addr", imem_addr, e_addr);
                end
            end
            if (if_valid && if_ready && !br_taken) begin
                if (deliv_q.size() == 0) begin
                    chk("deliver_unexpected", if_pc, 64'hX);
                end else begin
                    e_del = deliv_q.pop_front();
                    chk("deliver_pc", if_pc, e_del[95:32]);
                    chk("deliver_instr", {32'd0, if_instr}, {32'd0, e_del[31:0]});
                end
            end
        end
    end

    // Applies one cycle of inputs to the model and records what the DUT must show.
    task automatic model_cycle();
        logic [63:0] aligned;
        aligned = br_target & ~64'h3;
        if (m_full) begin
            if (if_ready && !br_taken) deliv_q.push_back({m_buf_pc, m_buf_instr});
            if (br_taken) begin
                m_full = 0;
                m_pc   = aligned;
            end else if (if_ready) begin
                m_full = 0;
            end
        end else begin
            if (imem_ack) begin
                addr_q.push_back(m_pc);
                if (br_taken) begin
                    m_pc    = aligned;
                    m_stale = 0;
                end else if (m_stale) begin
                    m_pc    = m_pend;
                    m_stale = 0;
                end else begin
                    m_buf_pc    = m_pc;
                    m_buf_instr = imem_rdata;
                    m_full      = 1;
                    m_pc        = m_pc + 64'd4;
                end
            end else if (br_taken) begin
                m_stale = 1;
                m_pend  = aligned;
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        if_ready   = 1'b0;
        br_taken   = 1'b0;
        br_target  = '0;

        // Reset held for two cycles
        step();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_instr", {32'd0, if_instr}, 64'd0);
        chk("rst_pc", if_pc, 64'd0);
        step();
        chk("rst2_req", {63'd0, imem_req}, 64'd0);
        chk("rst2_valid", {63'd0, if_valid}, 64'd0);
        reset = 1'b1;
        step();
        chk("rel_req", {63'd0, imem_req}, 64'd1);
        chk("rel_addr", imem_addr, 64'd0);
        chk("rel_valid", {63'd0, if_valid}, 64'd0);

        // Back-pressure on the first instruction
        imem_ack   = 1'b1;
        imem_rdata = 32'hD503201F;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, if_valid}, 64'd1);
            chk("bp_instr", {32'd0, if_instr}, 64'hD503201F);
            chk("bp_pc", if_pc, 64'd0);
            chk("bp_req", {63'd0, imem_req}, 64'd0);
            step();
        end
        if_ready = 1'b1;
        step();
        chk("bp_rel_valid", {63'd0, if_valid}, 64'd0);
        chk("bp_rel_addr", imem_addr, 64'd4);

        // Zero-wait stream, one instruction per two cycles
        for (int n = 1; n <= 3; n++) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hF8000000 + 32'(n);
            step();
            imem_ack = 1'b0;
            chk("st_valid", {63'd0, if_valid}, 64'd1);
            chk("st_pc", if_pc, 64'(4 * n));
            chk("st_instr", {32'd0, if_instr}, {32'd0, 32'hF8000000 + 32'(n)});
            chk("st_req", {63'd0, imem_req}, 64'd0);
            step();
            chk("st_gap_valid", {63'd0, if_valid}, 64'd0);
            chk("st_next_addr", imem_addr, 64'(4 * (n + 1)));
        end

        // Three wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            chk("ws_req", {63'd0, imem_req}, 64'd1);
            chk("ws_addr", imem_addr, 64'h10);
            chk("ws_valid", {63'd0, if_valid}, 64'd0);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A50010;
        step();
        imem_ack = 1'b0;
        chk("ws_load_valid", {63'd0, if_valid}, 64'd1);
        chk("ws_load_pc", if_pc, 64'h10);
        chk("ws_load_instr", {32'd0, if_instr}, 64'hA5A50010);
        step();
        chk("ws_after_valid", {63'd0, if_valid}, 64'd0);
        chk("ws_after_addr", imem_addr, 64'h14);

        // Redirect coinciding with ack in S_ISSUE
        br_taken   = 1'b1;
        br_target  = 64'h20;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00000BAD;
        step();
        br_taken = 1'b0;
        imem_ack = 1'b0;
        chk("ia_valid", {63'd0, if_valid}, 64'd0);
        chk("ia_addr", imem_addr, 64'h20);

        // Redirect while a request is in flight
        step();
        chk("dr_pre_addr", imem_addr, 64'h20);
        br_taken  = 1'b1;
        br_target = 64'h203;
        step();
        br_taken = 1'b0;
        chk("dr_hold_req", {63'd0, imem_req}, 64'd1);
        chk("dr_hold_addr", imem_addr, 64'h20);
        step();
        chk("dr_hold2_addr", imem_addr, 64'h20);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        chk("dr_valid", {63'd0, if_valid}, 64'd0);
        chk("dr_next_addr", imem_addr, 64'h200);

        // Redirect beats ready in S_HOLD
        imem_ack   = 1'b1;
        imem_rdata = 32'h00001234;
        step();
        imem_ack = 1'b0;
        chk("hr_valid", {63'd0, if_valid}, 64'd1);
        chk("hr_pc", if_pc, 64'h200);
        br_taken  = 1'b1;
        br_target = 64'h1000;
        step();
        br_taken = 1'b0;
        chk("hr_drop", {63'd0, if_valid}, 64'd0);
        chk("hr_addr", imem_addr, 64'h1000);

        // PC wrap at the top of the address space
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        imem_ack  = 1'b1;
        step();
        br_taken = 1'b0;
        imem_ack = 1'b0;
        chk("wr_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00000013;
        step();
        imem_ack = 1'b0;
        chk("wr_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wr_next_addr", imem_addr, 64'd0);

        // Reset during a request swallows the ack
        reset    = 1'b0;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("mr_req", {63'd0, imem_req}, 64'd0);
        chk("mr_valid", {63'd0, if_valid}, 64'd0);
        reset = 1'b1;
        step();
        chk("mr_rel_req", {63'd0, imem_req}, 64'd1);
        chk("mr_rel_addr", imem_addr, 64'd0);
        chk("mr_rel_valid", {63'd0, if_valid}, 64'd0);

        // Randomized traffic against the model
        m_pc        = 64'd0;
        m_pend      = 64'd0;
        m_buf_pc    = 64'd0;
        m_buf_instr = 32'd0;
        m_full      = 0;
        m_stale     = 0;
        sb_en       = 1;
        for (int c = 0; c < 3000; c++) begin
            imem_ack   = !m_full && ($urandom_range(0, 2) != 0);
            imem_rdata = $urandom;
            if_ready   = ($urandom_range(0, 3) != 0);
            br_taken   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0)
                br_target = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom)};
            else
                br_target = {$urandom, $urandom};
            model_cycle();
            step();
        end
        sb_en    = 0;
        imem_ack = 1'b0;
        br_taken = 1'b0;
        chk("sb_fetch_left", 64'(addr_q.size()), 64'd0);
        chk("sb_deliver_left", 64'(deliv_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_sequencer
`default_nettype wire
